// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a shared N:1 data mux with a registered valid/ready output.
// The winner's word is held in the output register until the consumer accepts it.
module mux_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       in_valid,
    input  logic [N_REQ*WIDTH-1:0] in_data,
    output logic [N_REQ-1:0]       in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy
);

    localparam int unsigned PtrW = $clog2(N_REQ);

    typedef enum logic {StIdle, StHold} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [PtrW-1:0]   win_idx;
    logic              found;

    // Rotating scan starting at ptr; first valid requester wins.
    always_comb begin : scan
        logic [PtrW-1:0] k;
        found   = 1'b0;
        win_idx = '0;
        k       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = PtrW'((32'(ptr_q) + i) % N_REQ);
            if (!found && in_valid[k]) begin
                found   = 1'b1;
                win_idx = k;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        data_d   = data_q;
        grant_d  = grant_q;
        in_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    in_ready[win_idx] = 1'b1;
                    data_d            = in_data[32'(win_idx)*WIDTH +: WIDTH];
                    sel_d             = win_idx;
                    grant_d           = '0;
                    grant_d[win_idx]  = 1'b1;
                    state_d           = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    grant_d = '0;
                    state_d = StIdle;
                    ptr_d   = (sel_q == PtrW'(N_REQ - 1)) ? '0 : sel_q + PtrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    // Output valid is the HOLD state itself, so it drops with the async reset.
    assign out_valid = (state_q == StHold);
    assign busy      = (state_q == StHold);
    assign out_data  = data_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [N+W-1:0] exp_q[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    task automatic expect_word(input int k, input logic [W-1:0] v);
        logic [N-1:0] g;
        g    = '0;
        g[k] = 1'b1;
        exp_q.push_back({g, v});
    endtask

    always @(negedge clk) begin : monitor
        logic [N+W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got grant %b data %h, expected none", grant, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({grant, out_data} !== e) begin
                    n_err++;
                    $display("FAIL word: got grant %b data %h, expected grant %b data %h",
                             grant, out_data, e[N+W-1:W], e[W-1:0]);
                end
            end
        end
    end

    initial begin
        // Reset
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_data", 32'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single request
        in_valid = 4'b0100; set_data(2, 8'hA5); out_ready = 1'b1;
        expect_word(2, 8'hA5);
        #1 check("single_in_ready", 32'(in_ready), 32'h4);
        tick();
        check("single_out_valid", 32'(out_valid), 1);
        check("single_out_data", 32'(out_data), 32'hA5);
        check("single_grant", 32'(grant), 32'h4);
        check("single_busy", 32'(busy), 1);
        in_valid = '0;
        tick();
        check("single_done_valid", 32'(out_valid), 0);
        check("single_done_grant", 32'(grant), 0);
        check("single_keep_data", 32'(out_data), 32'hA5);

        // All four valid, ptr back to 0
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        for (int k = 0; k < N; k++) set_data(k, 8'(8'h10 + k));
        in_valid = 4'b1111;
        for (int k = 0; k < N; k++) expect_word(k, 8'(8'h10 + k));
        expect_word(0, 8'h10);
        #1 check("all_first_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("all_out_valid_pattern", 32'(out_valid), 32'((i % 2) == 0));
        end
        in_valid = '0;

        // Backpressure (ptr = 1)
        out_ready = 1'b0; in_valid = 4'b0010; set_data(1, 8'h3C);
        expect_word(1, 8'h3C);
        tick();
        in_valid = 4'b0001; set_data(0, 8'h5A);
        expect_word(0, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_data", 32'(out_data), 32'h3C);
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_next_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("bp_next_grant", 32'(grant), 32'h1);
        in_valid = '0;
        tick();

        // Rotation and wrap (ptr = 1)
        in_valid = 4'b1000; set_data(3, 8'h77);
        expect_word(3, 8'h77);
        tick();
        in_valid = 4'b0011; set_data(0, 8'hA0); set_data(1, 8'hA1);
        expect_word(0, 8'hA0);
        expect_word(1, 8'hA1);
        tick();
        check("wrap_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 4'b0010;
        tick();
        tick();
        in_valid = 4'b1010; set_data(1, 8'hB1); set_data(3, 8'hB3);
        expect_word(3, 8'hB3);
        expect_word(1, 8'hB1);
        tick();
        check("rot_in_ready_3", 32'(in_ready), 32'h8);
        tick();
        in_valid = 4'b0010;
        tick();
        check("rot_in_ready_1", 32'(in_ready), 32'h2);
        tick();
        in_valid = '0;
        tick();

        // Async reset in HOLD; pending word is discarded
        out_ready = 1'b0; in_valid = 4'b0010; set_data(1, 8'hEE);
        tick();
        in_valid = '0;
        check("hold_before_rst", 32'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_grant", 32'(grant), 0);
        check("arst_out_data", 32'(out_data), 0);
        #1 rst = 1'b0;
        in_valid = 4'b1100; set_data(2, 8'hC2); set_data(3, 8'hC3); out_ready = 1'b1;
        expect_word(2, 8'hC2);
        #1 check("post_rst_in_ready", 32'(in_ready), 32'h4);
        tick();
        check("post_rst_grant", 32'(grant), 32'h4);
        in_valid = '0;
        tick();
        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
